regfile_mp: RTL and testbench

Parametrised multi-read-port register file for the MIPS datapath. It holds the architectural registers between the instruction register (which supplies register numbers) and the ALU (which consumes operands). It adds three things to a plain register file: a write port with same-cycle read bypass, an optional hardwired-zero register, and a self-clearing init sweep that runs after reset or on request.

---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass, optional hardwired zero
// register, and a self-clearing init sweep after reset or on CLEAR.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       RegWrite,
    input  logic [ADDR_W-1:0]          WriteReg,
    input  logic [DATA_W-1:0]          WriteData,
    input  logic                       RdEn,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadRegs,
    input  logic                       CLEAR,
    output logic [NUM_RD*DATA_W-1:0]   RdData,
    output logic                       RdValid,
    output logic                       BUSY
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                ready_op;
    logic                wr_ok;
    logic [DATA_W-1:0]   rd_word [NUM_RD];

    // CLEAR wins over any access issued in the same READY cycle
    assign ready_op = (state == ST_READY) && !CLEAR;
    assign wr_ok    = ready_op && RegWrite && !(HAS_ZERO && (WriteReg == '0));

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = ReadRegs[g*ADDR_W +: ADDR_W];

        always_comb begin
            rd_word[g] = regs[addr];
            if (HAS_ZERO && (addr == '0)) begin
                rd_word[g] = '0;
            end else if (wr_ok && (WriteReg == addr)) begin
                rd_word[g] = WriteData;
            end
        end
    end

    // Array has no reset; the sweep zeroes it one entry per cycle
    always_ff @(posedge CLK) begin
        if (state == ST_INIT) begin
            regs[ptr] <= '0;
        end else if (wr_ok) begin
            regs[WriteReg] <= WriteData;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_INIT;
            ptr     <= '0;
            BUSY    <= 1'b1;
            RdData  <= '0;
            RdValid <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    RdValid <= 1'b0;
                    if (CLEAR) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                        if (ptr == LAST_PTR) begin
                            state <= ST_READY;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                ST_READY: begin
                    if (CLEAR) begin
                        state   <= ST_INIT;
                        ptr     <= '0;
                        BUSY    <= 1'b1;
                        RdValid <= 1'b0;
                    end else begin
                        RdValid <= RdEn;
                        if (RdEn) begin
                            for (int unsigned i = 0; i < NUM_RD; i++) begin
                                RdData[i*DATA_W +: DATA_W] <= rd_word[i];
                            end
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed steps plus random traffic against an array model,
// with one instance using the hardwired zero register and one without.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              RegWrite;
    logic [AW-1:0]     WriteReg;
    logic [DW-1:0]     WriteData;
    logic              RdEn;
    logic [NR*AW-1:0]  ReadRegs;
    logic              CLEAR;
    logic [NR*DW-1:0]  rd_z, rd_n;
    logic              vld_z, vld_n, busy_z, busy_n;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [DW-1:0] mem_z [DEPTH];
    logic [DW-1:0] mem_n [DEPTH];
    logic [DW-1:0] exp_z [NR];
    logic [DW-1:0] exp_n [NR];
    int            left;
    bit            m_vld;

    always #5 CLK = ~CLK;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_z (
        .CLK(CLK), .RESET(RESET), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .RdEn(RdEn), .ReadRegs(ReadRegs), .CLEAR(CLEAR),
        .RdData(rd_z), .RdValid(vld_z), .BUSY(busy_z)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_n (
        .CLK(CLK), .RESET(RESET), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .RdEn(RdEn), .ReadRegs(ReadRegs), .CLEAR(CLEAR),
        .RdData(rd_n), .RdValid(vld_n), .BUSY(busy_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy_z", 64'(busy_z), 64'(left > 0));
        chk("busy_n", 64'(busy_n), 64'(left > 0));
        chk("valid_z", 64'(vld_z), 64'(m_vld));
        chk("valid_n", 64'(vld_n), 64'(m_vld));
        chk("rddata_z", 64'(rd_z), {exp_z[1], exp_z[0]});
        chk("rddata_n", 64'(rd_n), {exp_n[1], exp_n[0]});
    endtask

    task automatic model_reset();
        left  = DEPTH;
        m_vld = 1'b0;
        for (int i = 0; i < NR; i++) begin
            exp_z[i] = '0;
            exp_n[i] = '0;
        end
    endtask

    task automatic idle();
        RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        RdEn = 1'b0; ReadRegs = '0; CLEAR = 1'b0;
    endtask

    // One clock: advance the model from the inputs presented, then compare
    task automatic tick();
        int a;
        if (RESET) begin
            model_reset();
        end else if (left > 0) begin
            if (CLEAR) begin
                left = DEPTH;
            end else begin
                left--;
                if (left == 0) begin
                    for (int r = 0; r < DEPTH; r++) begin
                        mem_z[r] = '0;
                        mem_n[r] = '0;
                    end
                end
            end
            m_vld = 1'b0;
        end else if (CLEAR) begin
            left  = DEPTH;
            m_vld = 1'b0;
        end else begin
            if (RdEn) begin
                for (int i = 0; i < NR; i++) begin
                    a = int'(ReadRegs[i*AW +: AW]);
                    exp_n[i] = (RegWrite && int'(WriteReg) == a) ? WriteData : mem_n[a];
                    exp_z[i] = (a == 0) ? '0 : exp_n[i];
                    if (a != 0 && !(RegWrite && int'(WriteReg) == a)) exp_z[i] = mem_z[a];
                end
            end
            if (RegWrite) begin
                mem_n[WriteReg] = WriteData;
                if (WriteReg != '0) mem_z[WriteReg] = WriteData;
            end
            m_vld = RdEn;
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic wr(input int r, input logic [DW-1:0] d);
        idle();
        RegWrite = 1'b1; WriteReg = AW'(r); WriteData = d;
        tick();
    endtask

    task automatic rd(input int a0, input int a1);
        idle();
        RdEn = 1'b1; ReadRegs = {AW'(a1), AW'(a0)};
        tick();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle();
        // Reset asserted asynchronously; outputs must respond without a clock edge
        RESET = 1'b0;
        #3;
        RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        ticks(2);
        RESET = 1'b0;

        // Init sweep: BUSY high for 32 edges, checked every edge by the model
        ticks(DEPTH);
        rd(5, 5);
        idle();
        tick();

        // Write then read, and read-zero default on the other port
        wr(3, 32'hDEADBEEF);
        rd(3, 0);

        // Same-cycle bypass on both ports
        idle();
        RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'h12345678;
        RdEn = 1'b1; ReadRegs = {5'd7, 5'd7};
        tick();

        // Register 0: dropped with ZERO_REG=1, stored with ZERO_REG=0
        wr(0, 32'hFFFFFFFF);
        rd(0, 0);
        idle();
        RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h0BADF00D;
        RdEn = 1'b1; ReadRegs = {5'd0, 5'd3};
        tick();

        // Randomized traffic with occasional CLEAR
        for (int k = 0; k < 400; k++) begin
            RegWrite  = 1'($urandom_range(0, 1));
            WriteReg  = AW'($urandom_range(0, 7));
            WriteData = DW'($urandom);
            RdEn      = 1'($urandom_range(0, 1));
            ReadRegs  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            CLEAR     = ($urandom_range(0, 79) == 0);
            tick();
        end
        idle();
        ticks(DEPTH + 1);

        // CLEAR mid-operation with a write in the same cycle and during the sweep
        wr(1, 32'h11); wr(2, 32'h22); wr(3, 32'h33); wr(4, 32'h44);
        rd(1, 4);
        idle();
        CLEAR = 1'b1; RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 32'hAA; RdEn = 1'b1;
        tick();
        wr(2, 32'hAA);
        idle();
        ticks(DEPTH - 1);
        rd(1, 2);
        rd(3, 4);

        // CLEAR during the sweep restarts the full count
        idle();
        CLEAR = 1'b1;
        tick();
        idle();
        ticks(10);
        CLEAR = 1'b1;
        tick();
        idle();
        ticks(DEPTH);

        // Reset mid-sweep: 10 edges into INIT, held 3 cycles, then a full sweep
        wr(9, 32'hCAFEF00D);
        RESET = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        RESET = 1'b0;
        ticks(10);
        RESET = 1'b1;
        ticks(3);
        RESET = 1'b0;
        ticks(DEPTH);
        rd(9, 5);
        rd(2, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
